// File: rtl/alu_arbiter_if.sv
// Bundle between two ALU requesters, the shared combinational ALU and the response consumer.
// The slave view belongs to alu_arbiter; the master view is the surrounding environment.
interface alu_arbiter_if;
  logic       req0_valid;
  logic       req1_valid;
  logic       req0_ready;
  logic       req1_ready;
  logic [2:0] req0_op;
  logic [2:0] req1_op;
  logic [3:0] req0_a;
  logic [3:0] req0_b;
  logic [3:0] req1_a;
  logic [3:0] req1_b;
  logic [2:0] alu_op;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [3:0] alu_result;
  logic       alu_overflow;
  logic       alu_zero;
  logic       rsp_valid;
  logic       rsp_ready;
  logic       rsp_id;
  logic [3:0] rsp_result;
  logic       rsp_overflow;
  logic       rsp_zero;

  modport slave (
    input  req0_valid, req1_valid, req0_op, req1_op, req0_a, req0_b, req1_a, req1_b,
    input  alu_result, alu_overflow, alu_zero, rsp_ready,
    output req0_ready, req1_ready, alu_op, alu_a, alu_b,
    output rsp_valid, rsp_id, rsp_result, rsp_overflow, rsp_zero
  );

  modport master (
    output req0_valid, req1_valid, req0_op, req1_op, req0_a, req0_b, req1_a, req1_b,
    output alu_result, alu_overflow, alu_zero, rsp_ready,
    input  req0_ready, req1_ready, alu_op, alu_a, alu_b,
    input  rsp_valid, rsp_id, rsp_result, rsp_overflow, rsp_zero
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester arbiter for one shared combinational ALU: accept, execute, hold response.
// Round-robin or fixed priority; counts completed operations that overflowed (saturating).
module alu_arbiter #(
  parameter int PRIO_RR = 1,
  parameter int OVF_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_arbiter_if.slave     bus,
  output logic             busy,
  output logic [OVF_W-1:0] ovf_count
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0] state;
  logic       last_served;
  logic       grant;
  logic       accept;

  always_comb begin
    grant = 1'b0;
    if (bus.req0_valid && bus.req1_valid)
      grant = (PRIO_RR != 0) ? ~last_served : 1'b0;
    else if (bus.req1_valid)
      grant = 1'b1;
  end

  assign accept         = (state == IDLE) && (bus.req0_valid || bus.req1_valid);
  assign bus.req0_ready = (state == IDLE) && !grant && bus.req0_valid;
  assign bus.req1_ready = (state == IDLE) &&  grant && bus.req1_valid;
  assign bus.rsp_valid  = (state == RESP);
  assign busy           = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      last_served      <= 1'b1;
      bus.alu_op       <= '0;
      bus.alu_a        <= '0;
      bus.alu_b        <= '0;
      bus.rsp_id       <= 1'b0;
      bus.rsp_result   <= '0;
      bus.rsp_overflow <= 1'b0;
      bus.rsp_zero     <= 1'b0;
      ovf_count        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state       <= EXEC;
            last_served <= grant;
            bus.rsp_id  <= grant;
            bus.alu_op  <= grant ? bus.req1_op : bus.req0_op;
            bus.alu_a   <= grant ? bus.req1_a  : bus.req0_a;
            bus.alu_b   <= grant ? bus.req1_b  : bus.req0_b;
          end
        end
        EXEC: begin
          bus.rsp_result   <= bus.alu_result;
          bus.rsp_overflow <= bus.alu_overflow;
          bus.rsp_zero     <= bus.alu_zero;
          if (bus.alu_overflow && (ovf_count != '1))
            ovf_count <= ovf_count + 1'b1;
          state <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
